// File: rtl/wieg_regeling_pkg.sv
// wieg_regeling_pkg: shared types and helpers for the rocking controller
//   SET_W        width of a speed/amplitude setting (0..7)
//   state_t      controller states UIT/ACTIEF/RUST
//   eval_t       stress evaluation classes DALING/GELIJK/STIJGING
//   instelling_t packed (snel, hoek) setting pair
package wieg_regeling_pkg;
  localparam int SET_W = 3;
  typedef logic [SET_W-1:0] setting_t;
  typedef enum logic [1:0] {UIT, ACTIEF, RUST} state_t;
  typedef enum logic [1:0] {DALING, GELIJK, STIJGING} eval_t;
  typedef struct packed {
    setting_t snel;
    setting_t hoek;
  } instelling_t;
  // a decrease wins over "unchanged" when both flags are raised
  function automatic eval_t classify(input logic d, input logic g);
    return d ? DALING : g ? GELIJK : STIJGING;
  endfunction
  // next setting up: speed first, then amplitude with speed back to 1; (7,7) is the ceiling
  function automatic instelling_t escalate(input instelling_t i);
    instelling_t o;
    o = i;
    if (i.snel != setting_t'(7))
      o.snel = i.snel + setting_t'(1);
    else if (i.hoek != setting_t'(7)) begin
      o.snel = setting_t'(1);
      o.hoek = i.hoek + setting_t'(1);
    end
    return o;
  endfunction
  function automatic setting_t dec_sat(input setting_t v);
    return (v > setting_t'(1)) ? v - setting_t'(1) : setting_t'(1);
  endfunction
endpackage

// File: rtl/wieg_regeling_stap_gen.sv
// stap_gen: motor step pulse generator with period STAP_DIV*(8-snelheid)
//   clk       system clock
//   reset     asynchronous active-low reset
//   snelheid  current speed setting, 0 disables pulses
//   stap      one-cycle step pulse at the end of each period
module stap_gen
  import wieg_regeling_pkg::*;
#(
  parameter int STAP_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SET_W-1:0] snelheid,
  output logic             stap
);
  localparam int CW = $clog2(8 * STAP_DIV);
  logic [CW-1:0] cnt, eff, last_cnt;
  logic [SET_W-1:0] last;
  assign last_cnt = CW'(STAP_DIV * (8 - int'(snelheid)) - 1);
  // a speed change restarts the period in the very cycle it becomes visible
  assign eff = (snelheid != last) ? '0 : cnt;
  assign stap = (snelheid != '0) && (eff == last_cnt);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt  <= '0;
      last <= '0;
    end else begin
      cnt  <= (eff == last_cnt) ? '0 : eff + CW'(1);
      last <= snelheid;
    end
endmodule

// File: rtl/wieg_regeling.sv
// wieg_regeling: stress-driven rocking controller (speed/amplitude escalation, rest, step pulses)
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   aan       rocking enable (level)
//   evalTick  one-cycle strobe qualifying gedaald/gelijk
//   gedaald   stress decreased
//   gelijk    stress unchanged
//   snelheid  speed setting 0..7
//   hoek      amplitude setting 0..7
//   stap      one-cycle motor step pulse
//   rust      high while resting
module wieg_regeling
  import wieg_regeling_pkg::*;
#(
  parameter int STAP_DIV   = 1000,
  parameter int GELIJK_MAX = 3,
  parameter int RUST_MAX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aan,
  input  logic             evalTick,
  input  logic             gedaald,
  input  logic             gelijk,
  output logic [SET_W-1:0] snelheid,
  output logic [SET_W-1:0] hoek,
  output logic             stap,
  output logic             rust
);
  localparam int GW = $clog2(GELIJK_MAX + 1);
  localparam int RW = $clog2(RUST_MAX + 1);
  state_t state;
  instelling_t cur, prev;
  logic [GW-1:0] gcnt, gnext;
  logic [RW-1:0] rcnt, rnext;
  logic g_full, r_full;
  eval_t cls;
  assign cls = classify(gedaald, gelijk);
  assign gnext = gcnt + GW'(1);
  assign rnext = rcnt + RW'(1);
  assign g_full = gnext == GW'(GELIJK_MAX);
  assign r_full = rnext == RW'(RUST_MAX);
  assign snelheid = cur.snel;
  assign hoek = cur.hoek;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= UIT;
      cur   <= '0;
      prev  <= '0;
      gcnt  <= '0;
      rcnt  <= '0;
      rust  <= 1'b0;
    end else if (!aan) begin
      state <= UIT;
      cur   <= '0;
      prev  <= '0;
      gcnt  <= '0;
      rcnt  <= '0;
      rust  <= 1'b0;
    end else begin
      unique case (state)
        UIT: begin
          state <= ACTIEF;
          cur   <= {setting_t'(1), setting_t'(1)};
          prev  <= {setting_t'(1), setting_t'(1)};
          gcnt  <= '0;
          rcnt  <= '0;
        end
        ACTIEF:
          if (evalTick)
            unique case (cls)
              STIJGING: begin
                cur  <= prev;
                gcnt <= '0;
                rcnt <= '0;
              end
              GELIJK: begin
                rcnt <= '0;
                gcnt <= g_full ? '0 : gnext;
                if (g_full) begin
                  prev <= cur;
                  cur  <= escalate(cur);
                end
              end
              default: begin
                prev <= cur;
                gcnt <= '0;
                rcnt <= r_full ? '0 : rnext;
                if (r_full) begin
                  state <= RUST;
                  rust  <= 1'b1;
                end
              end
            endcase
        RUST:
          if (evalTick) begin
            if (cls == STIJGING) begin
              state <= ACTIEF;
              rust  <= 1'b0;
              cur   <= prev;
            end else
              cur <= {dec_sat(cur.snel), dec_sat(cur.hoek)};
          end
        default: state <= UIT;
      endcase
    end
  stap_gen #(.STAP_DIV(STAP_DIV)) u_stap (
    .clk      (clk),
    .reset    (reset),
    .snelheid (snelheid),
    .stap     (stap)
  );
endmodule

// File: tb/tb_wieg_regeling.sv
// tb_wieg_regeling: directed and randomized checks of wieg_regeling against a behavioural model
module tb_wieg_regeling;
  localparam int SD = 2, GM = 3, RM = 4;
  logic clk = 1'b0, reset = 1'b0, aan = 1'b0, evalTick = 1'b0, gedaald = 1'b0, gelijk = 1'b0;
  logic [2:0] snelheid, hoek;
  logic stap, rust;
  int total = 0, bad = 0;
  int m_mode, ms, mh, ps, ph, gc, rc, age;
  int cyc, pulses, first;
  always #5 clk = ~clk;
  wieg_regeling #(.STAP_DIV(SD), .GELIJK_MAX(GM), .RUST_MAX(RM)) dut (
    .clk      (clk),
    .reset    (reset),
    .aan      (aan),
    .evalTick (evalTick),
    .gedaald  (gedaald),
    .gelijk   (gelijk),
    .snelheid (snelheid),
    .hoek     (hoek),
    .stap     (stap),
    .rust     (rust)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; ms = 0; mh = 0; ps = 0; ph = 0; gc = 0; rc = 0; age = 0;
  endtask
  // settings seen as a linear ladder 0..48 = (hoek-1)*7 + (snel-1)
  task automatic model_edge(input bit a, input bit t, input bit d, input bit g);
    int old_s, idx;
    old_s = ms;
    if (!a) begin
      m_mode = 0; ms = 0; mh = 0; ps = 0; ph = 0; gc = 0; rc = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; ms = 1; mh = 1; ps = 1; ph = 1; gc = 0; rc = 0;
    end else if (t) begin
      if (m_mode == 1) begin
        if (!d && !g) begin
          ms = ps; mh = ph; gc = 0; rc = 0;
        end else if (!d) begin
          rc = 0; gc++;
          if (gc == GM) begin
            ps = ms; ph = mh; gc = 0;
            idx = (mh - 1) * 7 + (ms - 1) + 1;
            if (idx > 48) idx = 48;
            ms = idx % 7 + 1; mh = idx / 7 + 1;
          end
        end else begin
          ps = ms; ph = mh; gc = 0; rc++;
          if (rc == RM) begin m_mode = 2; rc = 0; end
        end
      end else begin
        if (!d && !g) begin
          m_mode = 1; ms = ps; mh = ph;
        end else begin
          ms = (ms > 1) ? ms - 1 : 1;
          mh = (mh > 1) ? mh - 1 : 1;
        end
      end
    end
    age = (ms != old_s) ? 0 : age + 1;
  endtask
  function automatic int exp_stap();
    int p;
    p = SD * (8 - ms);
    return (ms != 0 && (age % p) == p - 1) ? 1 : 0;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".snel"}, int'(snelheid), ms);
    chk({tag, ".hoek"}, int'(hoek), mh);
    chk({tag, ".rust"}, int'(rust), (m_mode == 2) ? 1 : 0);
    chk({tag, ".stap"}, int'(stap), exp_stap());
  endtask
  task automatic step(input bit a, input bit t, input bit d, input bit g, input string tag);
    aan = a; evalTick = t; gedaald = d; gelijk = g;
    @(posedge clk);
    model_edge(a, t, d, g);
    @(negedge clk);
    evalTick = 1'b0;
    check_all(tag);
    cyc++;
    if (stap === 1'b1) begin
      pulses++;
      if (first < 0) first = cyc;
    end
  endtask
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, ".snel"}, int'(snelheid), 0);
    chk({tag, ".hoek"}, int'(hoek), 0);
    chk({tag, ".stap"}, int'(stap), 0);
    chk({tag, ".rust"}, int'(rust), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic gelijk_ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 1, 0, 1, tag);
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst.snel", int'(snelheid), 0);
    chk("rst.hoek", int'(hoek), 0);
    chk("rst.stap", int'(stap), 0);
    chk("rst.rust", int'(rust), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "idle");
    step(1, 1, 1, 0, "aan");
    chk("aan.snel1", int'(snelheid), 1);
    chk("aan.hoek1", int'(hoek), 1);
    chk("aan.rust0", int'(rust), 0);
    cyc = 0; pulses = 0; first = -1;
    for (int i = 0; i < 28; i++) step(1, 0, 0, 0, "run");
    chk("stap.first", first, 13);
    chk("stap.count", pulses, 2);
    gelijk_ticks(3, "gel3");
    chk("gel3.snel", int'(snelheid), 2);
    chk("gel3.hoek", int'(hoek), 1);
    step(1, 1, 0, 0, "stijg");
    chk("stijg.snel", int'(snelheid), 1);
    chk("stijg.hoek", int'(hoek), 1);
    gelijk_ticks(60, "to73");
    chk("to73.snel", int'(snelheid), 7);
    chk("to73.hoek", int'(hoek), 3);
    gelijk_ticks(3, "wrap");
    chk("wrap.snel", int'(snelheid), 1);
    chk("wrap.hoek", int'(hoek), 4);
    gelijk_ticks(84, "to77");
    chk("to77.snel", int'(snelheid), 7);
    chk("to77.hoek", int'(hoek), 7);
    gelijk_ticks(3, "sat");
    chk("sat.snel", int'(snelheid), 7);
    chk("sat.hoek", int'(hoek), 7);
    step(0, 0, 0, 0, "off");
    step(1, 0, 0, 0, "on");
    gelijk_ticks(48, "to33");
    chk("to33.snel", int'(snelheid), 3);
    chk("to33.hoek", int'(hoek), 3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, "dal");
    chk("dal3.rust", int'(rust), 0);
    step(1, 1, 1, 0, "dal4");
    chk("dal4.rust", int'(rust), 1);
    step(1, 1, 0, 1, "rgel");
    step(1, 1, 0, 1, "rgel");
    chk("rgel.snel", int'(snelheid), 1);
    chk("rgel.hoek", int'(hoek), 1);
    step(1, 1, 0, 0, "rstijg");
    chk("rstijg.rust", int'(rust), 0);
    chk("rstijg.snel", int'(snelheid), 3);
    chk("rstijg.hoek", int'(hoek), 3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, "both");
    chk("both.snel", int'(snelheid), 3);
    chk("both.rust", int'(rust), 0);
    step(1, 1, 1, 1, "both4");
    chk("both4.rust", int'(rust), 1);
    step(1, 1, 0, 0, "leave");
    gelijk_ticks(4, "pre");
    async_reset("arst");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, "post");
    step(1, 0, 0, 0, "re_on");
    gelijk_ticks(9, "esc");
    step(0, 0, 0, 0, "drop");
    chk("drop.snel", int'(snelheid), 0);
    chk("drop.rust", int'(rust), 0);
    cyc = 0; pulses = 0; first = -1;
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, "uit");
    chk("uit.pulses", pulses, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) async_reset("rnd_rst");
      else step($urandom_range(39) != 0, $urandom_range(2) == 0, 1'($urandom_range(1)),
                1'($urandom_range(1)), "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wieg_regeling.md
WIEG_REGELING -- requirements
Module: wieg_regeling

Interface
REQ-001 Parameter STAP_DIV, default 1000, clock cycles per unit of step period.
REQ-002 Parameter GELIJK_MAX, default 3, consecutive "unchanged" evaluations before the setting is escalated.
REQ-003 Parameter RUST_MAX, default 4, consecutive "decreased" evaluations before entering rest.
REQ-004 Port clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port aan  in  1  rocking enable, level.
REQ-007 Port evalTick  in  1  one-cycle strobe marking a valid stress evaluation.
REQ-008 Port gedaald  in  1  stress decreased; sampled only on evalTick.
REQ-009 Port gelijk  in  1  stress unchanged; sampled only on evalTick.
REQ-010 Port snelheid  out  3  current rocking speed setting, 0..7.
REQ-011 Port hoek  out  3  current rocking amplitude setting, 0..7.
REQ-012 Port stap  out  1  one-cycle motor step pulse.
REQ-013 Port rust  out  1  high while in the RUST state.

Function
REQ-014 The evaluation class on evalTick SHALL be: DALING if gedaald=1 (priority, including gedaald=gelijk=1), GELIJK if gelijk=1 and gedaald=0, STIJGING otherwise.
REQ-015 The FSM SHALL have the states UIT, ACTIEF and RUST.
REQ-016 In UIT with aan=1, the next cycle SHALL load snelheid=1, hoek=1, prev=(1,1), clear both counters, and enter ACTIEF.
REQ-017 aan=0 in any state SHALL force UIT on the next cycle, with snelheid=hoek=0, rust=0, and stap inactive.
REQ-018 ACTIEF on STIJGING SHALL restore (snelheid,hoek) from prev and clear gelijkCnt and rustCnt.
REQ-019 ACTIEF on GELIJK SHALL clear rustCnt and increment gelijkCnt.
REQ-020 When gelijkCnt reaches GELIJK_MAX, ACTIEF SHALL in the same update copy the current setting into prev, escalate the setting, and clear gelijkCnt.
REQ-021 Escalation SHALL be: snelheid+1; if snelheid=7, set snelheid=1 and hoek+1; if both are 7, the setting stays (7,7).
REQ-022 ACTIEF on DALING SHALL hold the setting, copy it into prev, clear gelijkCnt, and increment rustCnt.
REQ-023 When rustCnt reaches RUST_MAX, ACTIEF SHALL enter RUST and clear rustCnt.
REQ-024 RUST SHALL drive rust=1.
REQ-025 In RUST, each evalTick with DALING or GELIJK SHALL decrement hoek saturating at 1, and decrement snelheid saturating at 1.
REQ-026 In RUST, STIJGING SHALL return to ACTIEF with (snelheid,hoek)=prev.
REQ-027 Step generator: with period P = STAP_DIV*(8-snelheid), a free counter SHALL count 0..P-1 and assert stap for one cycle when the count equals P-1, then wrap to 0.
REQ-028 The step counter SHALL restart from 0 on any change of snelheid; stap SHALL never be asserted in UIT or when snelheid=0.
REQ-029 Setting outputs SHALL be registered and update one cycle after the evalTick that causes the change.
REQ-030 evalTick SHALL be ignored in UIT and in the cycle of the UIT-to-ACTIEF transition.
REQ-031 Counter widths SHALL be clog2 of their maximum, with no overflow at maximum parameter values.

Reset
REQ-032 Asserting reset SHALL immediately force state=UIT, snelheid=0, hoek=0, prev=(0,0), all counters=0, stap=0, and rust=0, including mid-operation.
REQ-033 After reset is released, no output SHALL change until aan=1 is seen on a rising clk edge.

Structure
REQ-034 The state enumeration, the evaluation-class encoding and the 3-bit setting width SHALL live in the shared controller package.
REQ-035 The step generator SHALL be a sub-module named stap_gen, with inputs clk, reset and snelheid and output stap.

Verification
REQ-036 Reset, then aan=1 -> one cycle later snelheid=1, hoek=1, rust=0; with STAP_DIV=2, stap pulses every 14 cycles.
REQ-037 Three GELIJK evalTicks -> snelheid=2, hoek=1; then one STIJGING -> snelheid=1, hoek=1.
REQ-038 From (7,3), three GELIJK -> (1,4); from (7,7), three GELIJK -> (7,7) unchanged.
REQ-039 Four DALING -> rust=1; two further GELIJK from (3,3) -> (1,1); then one STIJGING -> rust=0 and setting restored to (3,3).
REQ-040 gedaald=gelijk=1 on evalTick -> treated as DALING (rustCnt increments, setting held).
REQ-041 reset asserted mid-ACTIEF, asynchronously between clock edges -> all outputs 0 immediately; aan dropped in ACTIEF -> UIT next cycle and no further stap pulses.
